psum_unpack: RTL and testbench
==============================

// Module: psum_unpack
// PURPOSE
// - Consumer end of the PE partial-sum output bus.
// - Accepts 48-bit accumulated words from a PE column drain, with a per-word mode bit.
// - Emits sign-extended results over a valid/ready stream:
//   - 8-bit mode: two packed lanes, serialised one per beat.
//   - 16-bit mode: one full-width result per word.
// - Sits between the PE array output and the output-buffer writer.
// PARAMETERS
// - PE_OUT_WIDTH  48  packed partial-sum word width (2 x 24-bit lane slots in 8-bit mode)
// - LANE_WIDTH    23  signed payload bits per 8-bit lane; the slot's MSB is a guard bit
// - OUT_WIDTH     48  result width; lanes and 16-bit words are sign-extended to it
// - CNT_WIDTH     16  width of the completed-word counter
// PORTS
// - clk         in   1             clock
// - reset       in   1             asynchronous, active-high reset
// - in_valid    in   1             in_data/in_8bit/in_last valid
// - in_ready    out  1             word accepted when in_valid && in_ready
// - in_data     in   PE_OUT_WIDTH  packed partial sum
// - in_8bit     in   1             0 = 16-bit word, 1 = two packed 8-bit lanes
// - in_last     in   1             last word of a tile
// - out_valid   out  1             result valid
// - out_ready   in   1             result consumed when out_valid && out_ready (fire)
// - out_data    out  OUT_WIDTH     signed result
// - out_lane    out  1             lane index (0 = bits[22:0], 1 = bits[46:24]); 0 in 16-bit mode
// - out_last    out  1             high on the final beat of an in_last word
// - words_done  out  CNT_WIDTH     count of fully drained words
// BEHAVIOUR
// - One clock domain (clk). reset is asynchronous and active-high.
// - Reset values: out_valid=0, out_data=0, out_lane=0, out_last=0, words_done=0, in_ready=1.
// - FSM states:
//   - EMPTY: no word held.
//   - HOLD16: 16-bit word held.
//   - HOLD8_L0 / HOLD8_L1: 8-bit word held, lane 0 / lane 1 presented.
// - Transitions:
//   - EMPTY: on accept -> HOLD8_L0 if in_8bit, else HOLD16.
//   - HOLD8_L0: on fire -> HOLD8_L1.
//   - HOLD16, HOLD8_L1: on fire with a simultaneous accept -> load new word (state from its in_8bit).
//   - HOLD16, HOLD8_L1: on fire without accept -> EMPTY.
// - in_ready = (state==EMPTY) || (fire && state in {HOLD16, HOLD8_L1}).
//   - Combinational from out_ready; no bubble on back-to-back words.
// - Latency: word accepted in cycle N; first result has out_valid=1 in N+1.
// - Throughput: 1 word/cycle in 16-bit mode; 1 word/2 cycles in 8-bit mode.
// - Holding register, in_8bit and in_last are captured only on accept.
// - out_data is derived from the held word and the state:
//   - HOLD16: sext(held[PE_OUT_WIDTH-1:0]).
//   - HOLD8_L0: sext(held[22:0]).
//   - HOLD8_L1: sext(held[46:24]).
//   - EMPTY: 0.
// - Guard bits held[23] and held[47] are never part of a lane value.
// - out_valid && !out_ready: out_data, out_lane and out_last hold stable; state unchanged.
// - out_last = held_last && state in {HOLD16, HOLD8_L1}.
// - words_done increments on fire in HOLD16 or HOLD8_L1.
//   - Wraps from 2^CNT_WIDTH-1 to 0; not cleared by in_last.
// - Mode switch between consecutive words is legal; each word uses its own captured in_8bit.
// - Reset mid-word (any state): the held word and any undrained lane are discarded.
//   - Outputs return to reset values immediately.
// CONFIGURATION
// - Macro PSUM_UNPACK_OVF_EN. When defined, adds:
//   - out_ovf (out, 1): high when the presented lane's guard bit is set.
//     - held[23] in HOLD8_L0; held[47] in HOLD8_L1; always 0 in HOLD16 and EMPTY.
//   - ovf_sticky (out, 1): set on any fire with out_ovf=1; cleared only by reset.
// - When not defined: neither port exists; guard bits are ignored.
// STRUCTURE
// - Shared package psum_pkg holds:
//   - localparams for lane slot width (24), LANE_WIDTH and guard-bit positions (23, 47);
//   - the FSM state encoding (EMPTY, HOLD16, HOLD8_L0, HOLD8_L1).
// - Sub-module psum_lane_ext: parameterised sign-extender (IN_W -> OUT_W).
//   - Three instances: 16-bit path, lane 0, lane 1.
// TESTING
// - 8-bit word in_data={1'b0,23'h7FFFFF,1'b0,23'h000005}, out_ready=1:
//   -> beat 1: out_data=5, lane 0; beat 2: out_data=48'hFFFF_FFFF_FFFF, lane 1; words_done=1.
// - Four back-to-back 16-bit words (48'h8000_0000_0001, ...), out_ready=1:
//   -> in_ready stays 1, one result per cycle, out_data equals input, words_done=4.
// - 8-bit word, out_ready=0 for 3 cycles:
//   -> out_data=lane0 stable, in_ready=0; lane 1 appears the cycle after out_ready rises.
// - Interleave 8-bit then 16-bit word with in_last=1 on the second:
//   -> 3 beats; out_last only on the 3rd beat; out_lane sequence 0,1,0.
// - Assert reset in HOLD8_L1:
//   -> out_valid=0 and words_done=0 immediately; next accepted word produces correct lanes.
// - PSUM_UNPACK_OVF_EN defined, in_data bit23=1, bit47=0, 8-bit mode:
//   -> out_ovf=1 on lane 0, 0 on lane 1; ovf_sticky=1 until reset.

Source files
------------

// File: rtl/psum_pkg.sv
// psum_pkg: lane slot geometry and FSM state encoding shared by psum_unpack and its bench-facing helpers
package psum_pkg;
  localparam int SLOT_W = 24;
  localparam int LANE_W = 23;
  localparam int GUARD0 = 23;
  localparam int GUARD1 = 47;
  typedef enum logic [1:0] {EMPTY, HOLD16, HOLD8_L0, HOLD8_L1} state_t;
endpackage

// File: rtl/psum_lane_ext.sv
// psum_lane_ext: sign-extends an IN_W-bit signed value to OUT_W bits
module psum_lane_ext #(
  parameter int IN_W  = 23,
  parameter int OUT_W = 48
) (
  input  logic [IN_W-1:0]  in_data,
  output logic [OUT_W-1:0] out_data
);
  assign out_data = OUT_W'($signed(in_data));
endmodule

// File: rtl/psum_unpack.sv
// psum_unpack: unpacks 48-bit PE partial sums (16-bit word or two 8-bit lanes) onto a valid/ready stream; PSUM_UNPACK_OVF_EN adds guard-bit overflow flags
module psum_unpack
  import psum_pkg::*;
#(
  parameter int PE_OUT_WIDTH = 48,
  parameter int LANE_WIDTH   = LANE_W,
  parameter int OUT_WIDTH    = 48,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PE_OUT_WIDTH-1:0] in_data,
  input  logic                    in_8bit,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_lane,
  output logic                    out_last,
  output logic [CNT_WIDTH-1:0]    words_done
`ifdef PSUM_UNPACK_OVF_EN
  ,
  output logic                    out_ovf,
  output logic                    ovf_sticky
`endif
);
  state_t state, state_nx;
  logic [PE_OUT_WIDTH-1:0] held;
  logic held_last;
  logic fire, accept, drain;
  logic [OUT_WIDTH-1:0] ext16, ext_l0, ext_l1;
  assign drain     = state == HOLD16 || state == HOLD8_L1;
  assign out_valid = state != EMPTY;
  assign fire      = out_valid && out_ready;
  // ready tracks out_ready on the final beat so back-to-back words leave no bubble
  assign in_ready  = state == EMPTY || (fire && drain);
  assign accept    = in_valid && in_ready;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = in_8bit ? HOLD8_L0 : HOLD16;
    else if (fire) state_nx = state == HOLD8_L0 ? HOLD8_L1 : EMPTY;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= EMPTY;
      held       <= '0;
      held_last  <= 1'b0;
      words_done <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        held      <= in_data;
        held_last <= in_last;
      end
      if (fire && drain) words_done <= words_done + 1'b1;
    end
  end
  psum_lane_ext #(.IN_W(PE_OUT_WIDTH), .OUT_W(OUT_WIDTH)) u_ext16 (
    .in_data (held),
    .out_data(ext16)
  );
  psum_lane_ext #(.IN_W(LANE_WIDTH), .OUT_W(OUT_WIDTH)) u_ext_l0 (
    .in_data (held[LANE_WIDTH-1:0]),
    .out_data(ext_l0)
  );
  psum_lane_ext #(.IN_W(LANE_WIDTH), .OUT_W(OUT_WIDTH)) u_ext_l1 (
    .in_data (held[SLOT_W +: LANE_WIDTH]),
    .out_data(ext_l1)
  );
  assign out_data = state == HOLD16   ? ext16  :
                    state == HOLD8_L0 ? ext_l0 :
                    state == HOLD8_L1 ? ext_l1 : '0;
  assign out_lane = state == HOLD8_L1;
  assign out_last = held_last && drain;
`ifdef PSUM_UNPACK_OVF_EN
  assign out_ovf = (state == HOLD8_L0 && held[GUARD0]) || (state == HOLD8_L1 && held[GUARD1]);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_sticky <= 1'b0;
    else if (fire && out_ovf) ovf_sticky <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_psum_unpack.sv
// tb_psum_unpack: randomized and directed checks of psum_unpack against a beat-queue reference model
module tb_psum_unpack;
  logic clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_8bit = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [47:0] in_data = '0;
  logic in_ready, out_valid, out_lane, out_last;
  logic [47:0] out_data;
  logic [15:0] words_done;
`ifdef PSUM_UNPACK_OVF_EN
  logic out_ovf, ovf_sticky;
`endif
  psum_unpack dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_8bit(in_8bit), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last), .words_done(words_done)
`ifdef PSUM_UNPACK_OVF_EN
    , .out_ovf(out_ovf), .ovf_sticky(ovf_sticky)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [47:0] d;
    bit lane;
    bit last;
    bit eow;
  } beat_t;
  beat_t q[$];
  logic [15:0] done = '0;
  bit last_acc;
  int n_chk = 0, n_fail = 0;
  logic [67:0] obs_vec;
  assign obs_vec = {out_valid, out_data, out_lane, out_last, in_ready, words_done};
  localparam logic [67:0] RST_VEC = {1'b0, 48'd0, 1'b0, 1'b0, 1'b1, 16'd0};
  function automatic logic [47:0] sx23(input logic [22:0] f);
    longint v;
    v = longint'(f);
    if (v >= 64'sd4194304) v -= 64'sd8388608;
    return 48'(v);
  endfunction
  function automatic bit exp_ir();
    return q.size() == 0 || (out_ready && q.size() == 1);
  endfunction
  function automatic logic [67:0] exp_vec();
    if (q.size() == 0) return {1'b0, 48'd0, 1'b0, 1'b0, exp_ir(), done};
    return {1'b1, q[0].d, q[0].lane, q[0].last, exp_ir(), done};
  endfunction
  task automatic push_word(input logic [47:0] w, input bit b8, input bit l);
    if (b8) begin
      q.push_back('{sx23(w[22:0]), 1'b0, 1'b0, 1'b0});
      q.push_back('{sx23(w[46:24]), 1'b1, l, 1'b1});
    end else q.push_back('{w, 1'b0, l, 1'b1});
  endtask
  task automatic drive(input logic v, input logic [47:0] d, input logic b, input logic l, input logic r);
    @(negedge clk);
    in_valid = v; in_data = d; in_8bit = b; in_last = l; out_ready = r;
    #1;
  endtask
  task automatic commit();
    bit ir, fire;
    beat_t b;
    ir = exp_ir();
    fire = q.size() > 0 && out_ready;
    @(posedge clk);
    if (fire) begin
      b = q.pop_front();
      if (b.eow) done = done + 16'd1;
    end
    last_acc = in_valid && ir;
    if (last_acc) push_word(in_data, in_8bit, in_last);
  endtask
  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    q.delete(); done = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    #1;
    n_chk++;
    if (obs_vec !== RST_VEC) begin n_fail++; $display("FAIL reset_hold: got %h expected %h", obs_vec, RST_VEC); end
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_chk++;
    if (obs_vec !== exp_vec()) begin n_fail++; $display("FAIL reset_release: got %h expected %h", obs_vec, exp_vec()); end
  endtask
  task automatic test_8bit_lanes();
    drive(1, {1'b0, 23'h7FFFFF, 1'b0, 23'h000005}, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) drive(0, '0, 0, 0, 1);
      n_chk++;
      if (obs_vec !== exp_vec()) begin n_fail++; $display("FAIL lanes8[%0d]: got %h expected %h", i, obs_vec, exp_vec()); end
      if (i == 1) begin
        n_chk++;
        if (out_data !== 48'd5 || out_lane !== 1'b0) begin n_fail++; $display("FAIL lanes8_beat1: got %h/%b expected 5/0", out_data, out_lane); end
      end
      if (i == 2) begin
        n_chk++;
        if (out_data !== 48'hFFFF_FFFF_FFFF || out_lane !== 1'b1) begin n_fail++; $display("FAIL lanes8_beat2: got %h/%b expected ffffffffffff/1", out_data, out_lane); end
      end
      commit();
    end
  endtask
  task automatic test_back_to_back();
    logic [47:0] w [4] = '{48'h8000_0000_0001, 48'h7FFF_FFFF_FFFF, 48'h0000_0000_0000, 48'hFFFF_0000_1234};
    logic [15:0] start;
    start = done;
    for (int i = 0; i < 6; i++) begin
      drive(i < 4, i < 4 ? w[i] : 48'd0, 0, 0, 1);
      n_chk++;
      if (obs_vec !== exp_vec()) begin n_fail++; $display("FAIL b2b16[%0d]: got %h expected %h", i, obs_vec, exp_vec()); end
      commit();
    end
    #1;
    n_chk++;
    if (words_done !== start + 16'd4) begin n_fail++; $display("FAIL b2b16_count: got %0d expected %0d", words_done, start + 16'd4); end
  endtask
  task automatic test_stall();
    drive(1, {1'b1, 23'h400000, 1'b1, 23'h123456}, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) drive(0, '0, 0, 0, i >= 4);
      n_chk++;
      if (obs_vec !== exp_vec()) begin n_fail++; $display("FAIL stall[%0d]: got %h expected %h", i, obs_vec, exp_vec()); end
      commit();
    end
  endtask
  task automatic test_mode_switch();
    bit sent = 0;
    drive(1, {1'b0, 23'h000010, 1'b0, 23'h7FFFF0}, 1, 0, 1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) drive(!sent, 48'h8123_4567_89AB, 0, 1, 1);
      n_chk++;
      if (obs_vec !== exp_vec()) begin n_fail++; $display("FAIL mode_switch[%0d]: got %h expected %h", i, obs_vec, exp_vec()); end
      commit();
      if (i > 0) sent |= last_acc;
    end
  endtask
  task automatic test_reset_mid();
    drive(1, {1'b0, 23'h2AAAAA, 1'b0, 23'h155555}, 1, 0, 1);
    commit();
    drive(0, '0, 0, 0, 1);
    commit();
    @(negedge clk);
    #1;
    n_chk++;
    if (out_lane !== 1'b1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL reset_mid_pre: got lane %b valid %b expected 1 1", out_lane, out_valid); end
    #1 reset = 1'b1;
    #1;
    q.delete(); done = '0;
    n_chk++;
    if (obs_vec !== RST_VEC) begin n_fail++; $display("FAIL reset_mid: got %h expected %h", obs_vec, RST_VEC); end
    @(negedge clk);
    reset = 1'b0;
    drive(1, {1'b0, 23'h400001, 1'b0, 23'h3FFFFF}, 1, 1, 1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) drive(0, '0, 0, 0, 1);
      n_chk++;
      if (obs_vec !== exp_vec()) begin n_fail++; $display("FAIL reset_mid_after[%0d]: got %h expected %h", i, obs_vec, exp_vec()); end
      commit();
    end
  endtask
  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), 48'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      n_chk++;
      if (obs_vec !== exp_vec()) begin n_fail++; $display("FAIL random[%0d]: got %h expected %h", i, obs_vec, exp_vec()); end
      commit();
    end
  endtask
  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      drive(1, 48'($urandom()), 0, 0, 1);
      commit();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 48'd7, 0, 0, 1);
      n_chk++;
      if (obs_vec !== exp_vec()) begin n_fail++; $display("FAIL wrap[%0d]: got %h expected %h", i, obs_vec, exp_vec()); end
      commit();
    end
    drive(0, '0, 0, 0, 1);
    n_chk++;
    if (words_done !== 16'd1) begin n_fail++; $display("FAIL wrap_final: got %0d expected 1", words_done); end
  endtask
`ifdef PSUM_UNPACK_OVF_EN
  task automatic test_ovf();
    do_reset();
    drive(1, {1'b0, 23'h000001, 1'b1, 23'h000002}, 1, 0, 1);
    commit();
    drive(0, '0, 0, 0, 1);
    n_chk++;
    if (out_ovf !== 1'b1 || ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_lane0: got %b/%b expected 1/0", out_ovf, ovf_sticky); end
    commit();
    drive(0, '0, 0, 0, 1);
    n_chk++;
    if (out_ovf !== 1'b0 || ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_lane1: got %b/%b expected 0/1", out_ovf, ovf_sticky); end
    commit();
    drive(1, 48'hFFFF_FFFF_FFFF, 0, 0, 1);
    commit();
    drive(0, '0, 0, 0, 1);
    n_chk++;
    if (out_ovf !== 1'b0 || ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_hold16: got %b/%b expected 0/1", out_ovf, ovf_sticky); end
    commit();
    do_reset();
    #1;
    n_chk++;
    if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_reset: got %b expected 0", ovf_sticky); end
  endtask
`endif
  initial begin
    test_reset();
    test_8bit_lanes();
    test_back_to_back();
    test_stall();
    test_mode_switch();
    test_reset_mid();
    test_random();
`ifdef PSUM_UNPACK_OVF_EN
    test_ovf();
`endif
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
